satatrn_txmux: RTL and testbench

- Parametrised, single-clock, N-channel packet arbiter for the SATA transport-layer TX path.
- Merges NCH AXI-stream-style FIS sources into one registered output stream toward the link layer.
- Packets are atomic: once a channel is granted, it owns the output until its last word.
- Channels flagged in HDR_MASK are held until their gate input is high, and get a DATA FIS header word (8'h46) prepended automatically.

---
 rtl/satatrn_txmux_if.sv | 30 +++
 rtl/satatrn_txmux.sv | 155 +++++++++++++++
 tb/tb_satatrn_txmux.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/satatrn_txmux_if.sv
// Handshake bundle between NCH FIS sources, the TX mux, and the link-layer sink.
// Signal names are from the mux's point of view (i_ = into the mux, o_ = out of it).
interface satatrn_txmux_if #(
  parameter int NCH = 2,
  parameter int DW  = 32
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]    i_valid;
  logic [NCH-1:0]    o_ready;
  logic [NCH*DW-1:0] i_data;
  logic [NCH-1:0]    i_last;
  logic [NCH-1:0]    i_gate;
  logic              o_valid;
  logic              i_ready;
  logic [DW-1:0]     o_data;
  logic              o_last;
  logic [CW-1:0]     o_chan;
  logic              o_busy;

  modport slave (
    input  i_valid, i_data, i_last, i_gate, i_ready,
    output o_ready, o_valid, o_data, o_last, o_chan, o_busy
  );

  modport master (
    output i_valid, i_data, i_last, i_gate, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_chan, o_busy
  );
endinterface

// File: rtl/satatrn_txmux.sv
// N-channel atomic-packet arbiter for the SATA transport TX path; 1-cycle registered output,
// output held while o_valid && !i_ready. Define SATATRN_TXMUX_RR_EN for round-robin arbitration.
module satatrn_txmux #(
  parameter int             NCH          = 2,
  parameter int             DW           = 32,
  parameter logic [NCH-1:0] HDR_MASK     = '0,
  parameter bit             OPT_LOWPOWER = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_reset,
  satatrn_txmux_if.slave io_tx
);
  localparam int            CW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [DW-1:0] HDR_WORD = DW'(8'h46);

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

  state_t        r_state, w_state_nx;
  logic          r_valid, w_valid_nx;
  logic [DW-1:0] r_data, w_data_nx;
  logic          r_last, w_last_nx;
  logic [CW-1:0] r_grant, w_grant_nx;

  logic [NCH-1:0] w_elig;
  logic [NCH-1:0] w_ready;
  logic [DW-1:0]  w_chan_data [NCH];
  logic           w_adv;
  logic           w_any;
  logic [CW-1:0]  w_sel;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      w_chan_data[k] = io_tx.i_data[k*DW +: DW];
    end
  end

  // Header channels wait for their gate; plain channels only need valid.
  assign w_elig = io_tx.i_valid & (~HDR_MASK | io_tx.i_gate);
  assign w_any  = |w_elig;
  assign w_adv  = !r_valid || io_tx.i_ready;

`ifdef SATATRN_TXMUX_RR_EN
  logic [CW-1:0] r_rr_ptr, w_rr_nx;
  logic          w_found;

  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      int idx;
      idx = int'(r_rr_ptr) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!w_found && w_elig[CW'(idx)]) begin
        w_found = 1'b1;
        w_sel   = CW'(idx);
      end
    end
  end
`else
  always_comb begin
    w_sel = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_elig[CW'(i)]) w_sel = CW'(i);
    end
  end
`endif

  always_comb begin
    w_state_nx = r_state;
    w_valid_nx = r_valid;
    w_data_nx  = r_data;
    w_last_nx  = r_last;
    w_grant_nx = r_grant;
    w_ready    = '0;
`ifdef SATATRN_TXMUX_RR_EN
    w_rr_nx    = r_rr_ptr;
`endif
    if (w_adv) begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            w_grant_nx = w_sel;
            w_valid_nx = 1'b1;
`ifdef SATATRN_TXMUX_RR_EN
            w_rr_nx    = (w_sel == CW'(NCH - 1)) ? '0 : w_sel + 1'b1;
`endif
            // Header word goes out first; the channel's first word is taken in PKT.
            if (HDR_MASK[w_sel]) begin
              w_data_nx  = HDR_WORD;
              w_last_nx  = 1'b0;
              w_state_nx = PKT;
            end else begin
              w_ready[w_sel] = 1'b1;
              w_data_nx      = w_chan_data[w_sel];
              w_last_nx      = io_tx.i_last[w_sel];
              w_state_nx     = io_tx.i_last[w_sel] ? IDLE : PKT;
            end
          end else begin
            w_valid_nx = 1'b0;
            if (OPT_LOWPOWER) begin
              w_data_nx = '0;
              w_last_nx = 1'b0;
            end
          end
        end
        PKT: begin
          w_ready[r_grant] = 1'b1;
          if (io_tx.i_valid[r_grant]) begin
            w_valid_nx = 1'b1;
            w_data_nx  = w_chan_data[r_grant];
            w_last_nx  = io_tx.i_last[r_grant];
            if (io_tx.i_last[r_grant]) w_state_nx = IDLE;
          end else begin
            w_valid_nx = 1'b0;
            if (OPT_LOWPOWER) begin
              w_data_nx = '0;
              w_last_nx = 1'b0;
            end
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_last   <= 1'b0;
      r_grant  <= '0;
`ifdef SATATRN_TXMUX_RR_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      r_state  <= w_state_nx;
      r_valid  <= w_valid_nx;
      r_data   <= w_data_nx;
      r_last   <= w_last_nx;
      r_grant  <= w_grant_nx;
`ifdef SATATRN_TXMUX_RR_EN
      r_rr_ptr <= w_rr_nx;
`endif
    end
  end

  // Nothing is accepted during reset so a source's pending word survives into the next packet.
  assign io_tx.o_ready = i_reset ? '0 : w_ready;
  assign io_tx.o_valid = r_valid;
  assign io_tx.o_data  = r_data;
  assign io_tx.o_last  = r_last;
  assign io_tx.o_chan  = r_grant;
  assign io_tx.o_busy  = (r_state != IDLE);
endmodule

// File: tb/tb_satatrn_txmux.sv
// Randomized bench for satatrn_txmux: 3 channels, channel 2 header-gated, against a queue-based model.
module tb_satatrn_txmux;
  localparam int             NCH      = 3;
  localparam int             DW       = 32;
  localparam logic [NCH-1:0] HDR_MASK = 3'b100;
  localparam int             NCYC     = 2400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  satatrn_txmux_if #(.NCH(NCH), .DW(DW)) bus ();

  satatrn_txmux #(
    .NCH(NCH), .DW(DW), .HDR_MASK(HDR_MASK), .OPT_LOWPOWER(1'b0)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_tx   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sources: each channel presents its current word until it is accepted.
  logic [31:0] src_data [NCH];
  int          src_left [NCH];

  function automatic void src_next(input int k);
    if (src_left[k] <= 1) src_left[k] = $urandom_range(1, 4);
    else                  src_left[k] = src_left[k] - 1;
    src_data[k] = $urandom;
  endfunction

  // Reference: expected registered outputs plus the owning channel (-1 when no packet is open).
  bit          m_valid, m_last;
  logic [31:0] m_data;
  int          m_chan, m_owner, m_rr;

  function automatic void model_reset();
    m_valid = 0; m_last = 0; m_data = '0; m_chan = 0; m_owner = -1; m_rr = 0;
  endfunction

  function automatic int pick(input logic [NCH-1:0] elig);
    for (int i = 0; i < NCH; i++) begin
`ifdef SATATRN_TXMUX_RR_EN
      int c = (m_rr + i) % NCH;
`else
      int c = i;
`endif
      if (elig[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    logic [NCH-1:0]    vld, gate, last, exp_rdy, elig;
    logic [NCH*DW-1:0] dat;
    int                p_valid, p_ready, p_gate, sel;
    bit                adv;

    model_reset();
    for (int k = 0; k < NCH; k++) begin
      src_left[k] = 0;
      src_next(k);
    end
    rst = 1'b1;
    bus.i_valid = '0; bus.i_data = '0; bus.i_last = '0; bus.i_gate = '0; bus.i_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check("o_valid", 32'(bus.o_valid), 32'(m_valid));
      check("o_data",  bus.o_data, m_data);
      check("o_last",  32'(bus.o_last), 32'(m_last));
      check("o_chan",  32'(bus.o_chan), 32'(m_chan));
      check("o_busy",  32'(bus.o_busy), 32'(m_owner >= 0));

      case ((cyc / 300) % 4)
        0:       begin p_valid = 100; p_ready = 100; p_gate = 100; end
        1:       begin p_valid = 70;  p_ready = 60;  p_gate = 100; end
        2:       begin p_valid = 85;  p_ready = 90;  p_gate = 25;  end
        default: begin p_valid = 50;  p_ready = 35;  p_gate = 50;  end
      endcase
      for (int k = 0; k < NCH; k++) begin
        vld[k]          = ($urandom_range(0, 99) < p_valid);
        gate[k]         = ($urandom_range(0, 99) < p_gate);
        last[k]         = (src_left[k] == 1);
        dat[k*DW +: DW] = src_data[k];
      end
      rst         = (cyc < 2) || ($urandom_range(0, 299) == 0);
      bus.i_valid = vld;
      bus.i_gate  = gate;
      bus.i_last  = last;
      bus.i_data  = dat;
      bus.i_ready = ($urandom_range(0, 99) < p_ready);
      #1;

      exp_rdy = '0;
      adv     = !m_valid || bus.i_ready;
      elig    = vld & (~HDR_MASK | gate);
      if (rst) begin
        model_reset();
      end else if (adv) begin
        if (m_owner < 0) begin
          sel = pick(elig);
          if (sel < 0) begin
            m_valid = 0;
          end else begin
            m_chan  = sel;
            m_valid = 1;
            m_rr    = (sel + 1) % NCH;
            if (HDR_MASK[sel]) begin
              m_data  = 32'h46;
              m_last  = 0;
              m_owner = sel;
            end else begin
              exp_rdy[sel] = 1'b1;
              m_data  = src_data[sel];
              m_last  = last[sel];
              m_owner = last[sel] ? -1 : sel;
            end
          end
        end else begin
          exp_rdy[m_owner] = 1'b1;
          if (vld[m_owner]) begin
            m_valid = 1;
            m_data  = src_data[m_owner];
            m_last  = last[m_owner];
            if (last[m_owner]) m_owner = -1;
          end else begin
            m_valid = 0;
          end
        end
      end
      check("o_ready", 32'(bus.o_ready), 32'(exp_rdy));

      for (int k = 0; k < NCH; k++) begin
        if (bus.o_ready[k] && vld[k]) src_next(k);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
